// File: rtl/wb_slave_mem_if.sv
// Wishbone classic slave bus bundle for wb_slave_mem.
// Clock and reset are plain ports on the block and are not part of this bundle.
interface wb_slave_mem_if;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;

  modport master (
    output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_stb_i, wbs_cyc_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  modport slave (
    input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_stb_i, wbs_cyc_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );
endinterface

// File: rtl/wb_slave_mem.sv
// Wishbone slave backed by an internal word memory.
// Adds programmable wait states and returns err for addresses outside the window.
module wb_slave_mem #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  wb_slave_mem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

  state_t      r_state, w_nxt;
  logic [3:0]  r_cnt;
  logic [29:0] r_adr;
  logic [31:0] r_wdat;
  logic [3:0]  r_sel;
  logic        r_we;
  logic        r_ack, r_err;
  logic [31:0] r_dat;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_req, w_commit, w_wr_en, w_ack_d, w_err_d, w_in_rng;
  logic [29:0] w_adr, w_off;
  logic [31:0] w_wdat;
  logic [3:0]  w_sel;
  logic        w_we;
  logic [AW-1:0] w_idx;
  logic        w_unused;

  assign w_req    = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign w_unused = &{1'b0, bus.wbs_adr_i[1:0]};

  // In IDLE the live bus is used so a zero-wait write can commit on its request edge
  assign w_adr  = (r_state == S_IDLE) ? bus.wbs_adr_i[31:2] : r_adr;
  assign w_wdat = (r_state == S_IDLE) ? bus.wbs_dat_i       : r_wdat;
  assign w_sel  = (r_state == S_IDLE) ? bus.wbs_sel_i       : r_sel;
  assign w_we   = (r_state == S_IDLE) ? bus.wbs_we_i        : r_we;

  // Word offset wraps for addresses below the base, so it reads as out of range
  assign w_off    = w_adr - BASE_ADDR[31:2];
  assign w_in_rng = (w_off[29:AW] == '0);
  assign w_idx    = w_off[AW-1:0];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: begin
        if (!bus.wbs_cyc_i)   w_nxt = S_IDLE;
        else if (r_cnt == '0) w_nxt = S_RESP;
      end
      S_RESP: w_nxt = S_HOLD;
      S_HOLD: if (!bus.wbs_stb_i || !bus.wbs_cyc_i) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_commit = (w_nxt == S_RESP) && (r_state != S_RESP);
    w_wr_en  = w_commit && !wb_rst_i && w_we && w_in_rng;
    w_ack_d  = (r_state == S_RESP) &&  w_in_rng;
    w_err_d  = (r_state == S_RESP) && !w_in_rng;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cnt  <= '0;
      r_adr  <= '0;
      r_wdat <= '0;
      r_sel  <= '0;
      r_we   <= 1'b0;
    end else if (r_state == S_IDLE && w_req) begin
      r_cnt  <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
      r_adr  <= bus.wbs_adr_i[31:2];
      r_wdat <= bus.wbs_dat_i;
      r_sel  <= bus.wbs_sel_i;
      r_we   <= bus.wbs_we_i;
    end else if (r_state == S_WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_ack_d;
      r_err <= w_err_d;
      if (w_err_d)              r_dat <= '0;
      else if (w_ack_d && !r_we) r_dat <= r_mem[w_idx];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_wr_en)
      for (int b = 0; b < 4; b++)
        if (w_sel[b]) r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
  end

  assign bus.wbs_ack_o = r_ack;
  assign bus.wbs_err_o = r_err;
  assign bus.wbs_dat_o = r_dat;
endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench for wb_slave_mem: a driver queues expected responses and a
// negedge monitor pops and compares each ack/err it sees.
module tb_wb_slave_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc_n = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] m_dat = 32'h0;

  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] dat;
  } exp_t;
  exp_t q[$];

  wb_slave_mem_if bus();

  wb_slave_mem #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    exp_t e;
    if (bus.wbs_ack_o || bus.wbs_err_o) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp ack=%0b err=%0b cycle=%0d", bus.wbs_ack_o, bus.wbs_err_o, cyc_n);
      end else begin
        e = q.pop_front();
        checks++;
        if (cyc_n != e.cyc) begin
          errors++; $display("FAIL latency got cycle %0d want %0d", cyc_n, e.cyc);
        end
        checks++;
        if (bus.wbs_err_o != e.err || bus.wbs_ack_o != !e.err) begin
          errors++; $display("FAIL term got ack=%0b err=%0b want err=%0b", bus.wbs_ack_o, bus.wbs_err_o, e.err);
        end
        checks++;
        if (bus.wbs_dat_o !== e.dat) begin
          errors++; $display("FAIL dat_o got %08h want %08h", bus.wbs_dat_o, e.dat);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++; $display("FAIL %s got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;   bus.wbs_sel_i = '0;
  endtask

  // Called just after a negedge; returns just after a negedge with the bus idle.
  task automatic do_req(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit exp_err, input logic [31:0] exp_rd,
                        input bit hold, input bit scramble);
    exp_t e;
    bit   seen = 0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
    e.cyc = cyc_n + 1 + 3;
    e.err = exp_err;
    e.dat = exp_err ? 32'h0 : (we ? m_dat : exp_rd);
    m_dat = e.dat;
    q.push_back(e);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (i == 0 && scramble) begin
        bus.wbs_adr_i = adr ^ 32'h30; bus.wbs_dat_i = ~dat;
        bus.wbs_sel_i = 4'h0;         bus.wbs_we_i  = ~we;
      end
      if (bus.wbs_ack_o || bus.wbs_err_o) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL timeout adr=%08h", adr);
      if (q.size() > 0) void'(q.pop_back());
    end
    if (hold) @(negedge clk);
    idle_bus();
    @(negedge clk);
  endtask

  initial begin
    idle_bus();
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
    chk("rst_err", {31'h0, bus.wbs_err_o}, 32'h0);
    chk("rst_dat", bus.wbs_dat_o, 32'h0);

    rst = 1'b0;
    do_req(1, 32'h0,   32'h00C0FFEE, 4'hF, 0, 0, 0, 0);
    do_req(1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 0, 0, 1);
    do_req(0, 32'h10,  32'h0,        4'hF, 0, 32'hDEADBEEF, 0, 0);
    do_req(1, 32'h20,  32'h11223344, 4'hF, 0, 0, 0, 0);
    do_req(1, 32'h20,  32'hAABBCCDD, 4'b0101, 0, 0, 0, 0);
    do_req(0, 32'h20,  32'h0,        4'hF, 0, 32'h11BB33DD, 0, 0);
    do_req(0, 32'h400, 32'h0,        4'hF, 1, 0, 0, 0);
    do_req(1, 32'h400, 32'hFFFFFFFF, 4'hF, 1, 0, 0, 0);
    do_req(0, 32'h0,   32'h0,        4'hF, 0, 32'h00C0FFEE, 0, 0);
    do_req(1, 32'h10,  32'h0,        4'h0, 0, 0, 0, 0);
    do_req(0, 32'h10,  32'h0,        4'hF, 0, 32'hDEADBEEF, 1, 0);
    do_req(0, 32'h23,  32'h0,        4'hF, 0, 32'h11BB33DD, 0, 0);
    do_req(0, 32'hFFFFFFFC, 32'h0,   4'hF, 1, 0, 0, 0);
    do_req(1, 32'h3FC, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0);
    do_req(0, 32'h3FC, 32'h0,        4'hF, 0, 32'hCAFEF00D, 0, 0);
    do_req(1, 32'h30,  32'h0BADF00D, 4'hF, 0, 0, 0, 0);
    do_req(1, 32'h40,  32'h12345678, 4'hF, 0, 0, 1, 0);
    do_req(0, 32'h30,  32'h0,        4'hF, 0, 32'h0BADF00D, 0, 0);

    // Abort: cyc dropped while the write is waiting
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = 32'h30; bus.wbs_dat_i = 32'h5555AAAA; bus.wbs_sel_i = 4'hF;
    @(negedge clk);
    idle_bus();
    repeat (6) @(negedge clk);
    do_req(0, 32'h30, 32'h0, 4'hF, 0, 32'h0BADF00D, 0, 0);

    // Reset lands on the edge that would have committed the write
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = 32'h40; bus.wbs_dat_i = 32'hFFFFFFFF; bus.wbs_sel_i = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("wait_rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
    chk("wait_rst_err", {31'h0, bus.wbs_err_o}, 32'h0);
    chk("wait_rst_dat", bus.wbs_dat_o, 32'h0);
    rst = 1'b0;
    m_dat = 32'h0;
    idle_bus();
    repeat (4) @(negedge clk);
    do_req(0, 32'h40, 32'h0, 4'hF, 0, 32'h12345678, 0, 0);

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
